// File: rtl/vlsu_axi_txn_limiter.sv
// Outstanding-burst limiter and status tracker between the VLSU and its AXI memory cut.
// Optional stall counters are compiled in with VLSU_TXN_PERF_EN.
module vlsu_axi_txn_limiter #(
   parameter int unsigned MaxRdTxn = 8,
   parameter int unsigned MaxWrTxn = 8,
   parameter int unsigned ArWidth  = 64,
   parameter int unsigned AwWidth  = 64,
   parameter int unsigned WWidth   = 73,
   parameter int unsigned RWidth   = 70,
   parameter int unsigned BWidth   = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ArWidth-1:0] slv_ar_i,
   input  logic              slv_ar_valid_i,
   output logic              slv_ar_ready_o,
   output logic [ArWidth-1:0] mst_ar_o,
   output logic              mst_ar_valid_o,
   input  logic              mst_ar_ready_i,
   input  logic [AwWidth-1:0] slv_aw_i,
   input  logic              slv_aw_valid_i,
   output logic              slv_aw_ready_o,
   output logic [AwWidth-1:0] mst_aw_o,
   output logic              mst_aw_valid_o,
   input  logic              mst_aw_ready_i,
   input  logic [WWidth-1:0]  slv_w_i,
   input  logic              slv_w_last_i,
   input  logic              slv_w_valid_i,
   output logic              slv_w_ready_o,
   output logic [WWidth-1:0]  mst_w_o,
   output logic              mst_w_last_o,
   output logic              mst_w_valid_o,
   input  logic              mst_w_ready_i,
   input  logic [RWidth-1:0]  mst_r_i,
   input  logic              mst_r_last_i,
   input  logic [1:0]        mst_r_resp_i,
   input  logic              mst_r_valid_i,
   output logic              mst_r_ready_o,
   output logic [RWidth-1:0]  slv_r_o,
   output logic              slv_r_last_o,
   output logic              slv_r_valid_o,
   input  logic              slv_r_ready_i,
   input  logic [BWidth-1:0]  mst_b_i,
   input  logic [1:0]        mst_b_resp_i,
   input  logic              mst_b_valid_i,
   output logic              mst_b_ready_o,
   output logic [BWidth-1:0]  slv_b_o,
   output logic              slv_b_valid_o,
   input  logic              slv_b_ready_i,
   output logic              load_pending_o,
   output logic              store_pending_o,
   output logic              load_complete_o,
   output logic              store_complete_o,
   output logic              err_o,
   input  logic              err_clr_i
`ifdef VLSU_TXN_PERF_EN
   ,
   output logic [31:0]       rd_stall_cnt_o,
   output logic [31:0]       wr_stall_cnt_o
`endif
);

   localparam int unsigned RdCntW = $clog2(MaxRdTxn + 1);
   localparam int unsigned WrCntW = $clog2(MaxWrTxn + 1);

   logic [RdCntW-1:0] rd_cnt;
   logic [WrCntW-1:0] wr_cnt;
   logic [WrCntW-1:0] w_credit;
   logic              load_complete_q, store_complete_q, err_q;

   logic rd_ok, wr_ok, w_ok;
   logic ar_hs, aw_hs, w_last_hs, r_hs, r_last_hs, b_hs;
   logic rd_underflow, wr_underflow, resp_err;

   // Gates look only at the registered counts; a retire frees a slot one cycle later.
   assign rd_ok = rd_cnt < RdCntW'(MaxRdTxn);
   assign wr_ok = wr_cnt < WrCntW'(MaxWrTxn);
   assign w_ok  = w_credit != '0;

   assign mst_ar_o       = slv_ar_i;
   assign mst_ar_valid_o = slv_ar_valid_i & rd_ok;
   assign slv_ar_ready_o = mst_ar_ready_i & rd_ok;
   assign mst_aw_o       = slv_aw_i;
   assign mst_aw_valid_o = slv_aw_valid_i & wr_ok;
   assign slv_aw_ready_o = mst_aw_ready_i & wr_ok;
   assign mst_w_o        = slv_w_i;
   assign mst_w_last_o   = slv_w_last_i;
   assign mst_w_valid_o  = slv_w_valid_i & w_ok;
   assign slv_w_ready_o  = mst_w_ready_i & w_ok;

   assign slv_r_o        = mst_r_i;
   assign slv_r_last_o   = mst_r_last_i;
   assign slv_r_valid_o  = mst_r_valid_i;
   assign mst_r_ready_o  = slv_r_ready_i;
   assign slv_b_o        = mst_b_i;
   assign slv_b_valid_o  = mst_b_valid_i;
   assign mst_b_ready_o  = slv_b_ready_i;

   assign ar_hs     = slv_ar_valid_i & mst_ar_ready_i & rd_ok;
   assign aw_hs     = slv_aw_valid_i & mst_aw_ready_i & wr_ok;
   assign w_last_hs = slv_w_valid_i & mst_w_ready_i & w_ok & slv_w_last_i;
   assign r_hs      = mst_r_valid_i & slv_r_ready_i;
   assign r_last_hs = r_hs & mst_r_last_i;
   assign b_hs      = mst_b_valid_i & slv_b_ready_i;

   // A retire with nothing outstanding (and no issue to absorb it) is a protocol error.
   assign rd_underflow = r_last_hs & ~ar_hs & (rd_cnt == '0);
   assign wr_underflow = b_hs & ~aw_hs & (wr_cnt == '0);
   assign resp_err     = (r_hs & (mst_r_resp_i == 2'b10 || mst_r_resp_i == 2'b11)) |
                         (b_hs & (mst_b_resp_i == 2'b10 || mst_b_resp_i == 2'b11));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_cnt           <= '0;
         wr_cnt           <= '0;
         w_credit         <= '0;
         load_complete_q  <= 1'b0;
         store_complete_q <= 1'b0;
         err_q            <= 1'b0;
      end else begin
         if (ar_hs && !r_last_hs)             rd_cnt <= rd_cnt + RdCntW'(1);
         else if (r_last_hs && !ar_hs && !rd_underflow) rd_cnt <= rd_cnt - RdCntW'(1);

         if (aw_hs && !b_hs)                  wr_cnt <= wr_cnt + WrCntW'(1);
         else if (b_hs && !aw_hs && !wr_underflow) wr_cnt <= wr_cnt - WrCntW'(1);

         if (aw_hs && !w_last_hs)             w_credit <= w_credit + WrCntW'(1);
         else if (w_last_hs && !aw_hs)        w_credit <= w_credit - WrCntW'(1);

         load_complete_q  <= r_last_hs & ~rd_underflow;
         store_complete_q <= b_hs & ~wr_underflow;

         if (rd_underflow || wr_underflow || resp_err) err_q <= 1'b1;
         else if (err_clr_i)                           err_q <= 1'b0;
      end
   end

   assign load_pending_o   = rd_cnt != '0;
   assign store_pending_o  = wr_cnt != '0;
   assign load_complete_o  = load_complete_q;
   assign store_complete_o = store_complete_q;
   assign err_o            = err_q;

`ifdef VLSU_TXN_PERF_EN
   logic [31:0] rd_stall_q, wr_stall_q;

   // Cycles lost to the read limit, and to the write limit or missing W credit.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_stall_q <= '0;
         wr_stall_q <= '0;
      end else begin
         if (slv_ar_valid_i && !rd_ok) rd_stall_q <= rd_stall_q + 32'd1;
         if ((slv_aw_valid_i && !wr_ok) || (slv_w_valid_i && !w_ok))
            wr_stall_q <= wr_stall_q + 32'd1;
      end
   end

   assign rd_stall_cnt_o = rd_stall_q;
   assign wr_stall_cnt_o = wr_stall_q;
`endif

endmodule

// File: doc/vlsu_axi_txn_limiter.md
Name: vlsu_axi_txn_limiter

Overview:
Parametrised transaction limiter and tracker between Ara's VLSU internals (address generator, vldu, vstu) and the AXI cut toward memory.
- Caps outstanding read and write bursts independently.
- Forbids W beats from running ahead of accepted AW bursts.
- Produces load/store pending and completion status, plus sticky error reporting.
- Generalises the fixed single-cut VLSU memory path with configurable depth, payload widths and optional performance counters.

Parameters:
MaxRdTxn, 8, max outstanding AR bursts (1..255)
MaxWrTxn, 8, max outstanding AW bursts awaiting B (1..255)
ArWidth, 64, opaque AR payload bits
AwWidth, 64, opaque AW payload bits
WWidth, 73, opaque W payload bits (W last is a separate port)
RWidth, 70, opaque R payload bits (R last/resp are separate ports)
BWidth, 8, opaque B payload bits (B resp is a separate port)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
slv_ar_i / slv_ar_valid_i / slv_ar_ready_o  in/in/out  ArWidth/1/1  AR from address generator
mst_ar_o / mst_ar_valid_o / mst_ar_ready_i  out/out/in  ArWidth/1/1  AR to memory
slv_aw_i / slv_aw_valid_i / slv_aw_ready_o  in/in/out  AwWidth/1/1  AW from address generator
mst_aw_o / mst_aw_valid_o / mst_aw_ready_i  out/out/in  AwWidth/1/1  AW to memory
slv_w_i / slv_w_last_i / slv_w_valid_i / slv_w_ready_o  in/in/in/out  WWidth/1/1/1  W from vstu
mst_w_o / mst_w_last_o / mst_w_valid_o / mst_w_ready_i  out/out/out/in  WWidth/1/1/1  W to memory
mst_r_i / mst_r_last_i / mst_r_resp_i / mst_r_valid_i / mst_r_ready_o  in/in/in/in/out  RWidth/1/2/1/1  R from memory
slv_r_o / slv_r_last_o / slv_r_valid_o / slv_r_ready_i  out/out/out/in  RWidth/1/1/1  R to vldu
mst_b_i / mst_b_resp_i / mst_b_valid_i / mst_b_ready_o  in/in/in/out  BWidth/2/1/1  B from memory
slv_b_o / slv_b_valid_o / slv_b_ready_i  out/out/in  BWidth/1/1  B to vstu
load_pending_o  out  1  rd_cnt != 0
store_pending_o  out  1  wr_cnt != 0
load_complete_o  out  1  one-cycle pulse per retired read burst
store_complete_o  out  1  one-cycle pulse per retired write burst
err_o  out  1  sticky error flag
err_clr_i  in  1  clears err_o

Behaviour:
- Payloads, last bits and R/B ready/valid are combinational pass-throughs. Only the valid/ready pairs of AR, AW and W are gated.
- Counters rd_cnt, wr_cnt and w_credit are each $clog2(Max+1) bits wide and reset to 0.
- rd_cnt:
  - Increments on an mst AR handshake.
  - Decrements on an mst R handshake with r_last=1.
  - Both in the same cycle: unchanged.
- AR gate: mst_ar_valid_o = slv_ar_valid_i && rd_cnt<MaxRdTxn; slv_ar_ready_o = mst_ar_ready_i && rd_cnt<MaxRdTxn.
  - No same-cycle credit bypass. At rd_cnt==Max, AR stalls even if a retire occurs that cycle; it proceeds the following cycle.
- wr_cnt: increments on an mst AW handshake, decrements on an mst B handshake. AW gate is analogous to the AR gate, using MaxWrTxn.
- w_credit:
  - Increments on AW handshake.
  - Decrements on a W handshake with w_last=1.
  - W is gated (mst_w_valid_o=0, slv_w_ready_o=0) while w_credit==0.
  - AW handshake and W-last in the same cycle: unchanged.
  - A W beat is never forwarded in the same cycle as the AW it belongs to.
- Underflow: R-last with rd_cnt==0, or B with wr_cnt==0, leaves the counter at 0 and sets err_o.
- err_o is also set by r_resp or b_resp ∈ {SLVERR=2, DECERR=3} on a handshake.
  - err_o clears the cycle after err_clr_i=1.
  - If a set and err_clr_i occur in the same cycle, set wins.
- load_complete_o / store_complete_o are registered, asserted the cycle after the R-last / B handshake, one pulse per burst.
- Reset (rst_ni=0 at a clock edge): all counters, err_o and pulse registers are 0 after that edge. All outputs derived from them are 0. Bursts in flight are forgotten; no drain is performed.
- Reset values of outputs:
  - pending, complete and err outputs: 0.
  - Gated valids: 0, because credits are 0 for W; AR/AW valids follow the slave inputs.

Optional Feature:
VLSU_TXN_PERF_EN
- Defined: adds outputs rd_stall_cnt_o and wr_stall_cnt_o, 32 bits each, reset to 0, wrapping at 2^32.
  - rd_stall_cnt_o counts cycles where slv_ar_valid_i=1 but AR is blocked by rd_cnt==MaxRdTxn.
  - wr_stall_cnt_o counts cycles where AW is blocked by the limit, or W is blocked by w_credit==0.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- MaxRdTxn=2; issue 3 ARs back-to-back with mst_ar_ready_i=1 and no R → ARs 1–2 pass, 3rd stalls; load_pending_o=1; after R-last, 3rd AR is accepted on the next cycle; load_complete_o pulses once per R-last.
- W presented before any AW → mst_w_valid_o=0 until the AW handshake; first W beat appears no earlier than the cycle after it; 4-beat burst forwarded, w_credit returns to 0.
- Same-cycle AW handshake and B handshake with wr_cnt=1 → wr_cnt stays 1; store_complete_o pulses next cycle; store_pending_o stays 1.
- B with b_resp=2 → err_o=1 and held; err_clr_i pulse → err_o=0 next cycle; spurious R-last with rd_cnt=0 → err_o=1, rd_cnt stays 0.
- rst_ni=0 for one edge with rd_cnt=2, wr_cnt=1 → all counters and status outputs 0 next cycle; a new AR is accepted immediately.
- With VLSU_TXN_PERF_EN: hold AR blocked 5 cycles → rd_stall_cnt_o=5.
